// File: rtl/controle_registrador_deslocamento_pkg.sv
// Shared definitions for the shift-chain controller: chain mode codes and FSM states.
package pkg_registrador;

   localparam logic [1:0] MODO_CARGA      = 2'b00;
   localparam logic [1:0] MODO_DESLOCA    = 2'b01;
   localparam logic [1:0] MODO_REALIMENTA = 2'b10;
   localparam logic [1:0] MODO_MANTEM     = 2'b11;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CARGA   = 2'd1,
      DESLOCA = 2'd2,
      FIM     = 2'd3
   } estado_t;

endpackage

// File: rtl/controle_registrador_deslocamento_contador_bits.sv
// Down counter of remaining bits: synchronous load, enable, and a zero flag.
module contador_bits #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          carga_i,
   input  logic          en_i,
   input  logic [CW-1:0] valor_i,
   output logic [CW-1:0] contagem_o,
   output logic          zero_o
);

   logic [CW-1:0] contagem_q;

   // Stops at zero rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         contagem_q <= '0;
      end else if (carga_i) begin
         contagem_q <= valor_i;
      end else if (en_i && (contagem_q != '0)) begin
         contagem_q <= contagem_q - CW'(1);
      end
   end

   assign contagem_o = contagem_q;
   assign zero_o     = (contagem_q == '0);

endmodule

// File: rtl/controle_registrador_deslocamento.sv
// Sequences a WIDTH-stage flip-flop chain through load/shift/hold and
// serializes the chain output LSB first, with a done pulse per word.
module controle_registrador_deslocamento
   import pkg_registrador::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dado,
   input  logic             pausa,
   input  logic             serial_q,
   output logic             ch1,
   output logic             ch0,
   output logic [WIDTH-1:0] valores_registrador,
   output logic             bit_saida,
   output logic             bit_valido,
   output logic             done,
   output logic             ocupado,
   output logic [CW-1:0]    contagem_uns
);

   estado_t          estado_q, estado_d;
   logic [1:0]       modo_q, modo_d;
   logic [WIDTH-1:0] valores_q, valores_d;
   logic             in_ready_q;
   logic             bit_saida_q, bit_saida_d;
   logic             bit_valido_q, bit_valido_d;
   logic             done_q;
   logic             ocupado_q, ocupado_d;
   logic [CW-1:0]    uns_q, uns_d;

   logic             cnt_carga, cnt_en, cnt_zero;
   logic [CW-1:0]    cnt_valor, cnt_contagem;
   logic             amostra, ultimo;

   assign cnt_valor = CW'(WIDTH);

   contador_bits #(.CW(CW)) u_contador (
      .clk        (clk),
      .rst_n      (rst_n),
      .carga_i    (cnt_carga),
      .en_i       (cnt_en),
      .valor_i    (cnt_valor),
      .contagem_o (cnt_contagem),
      .zero_o     (cnt_zero)
   );

   // A sample happens on edges where the chain actually sees the shift mode.
   assign amostra = (estado_q == DESLOCA) && (modo_q == MODO_DESLOCA) && !cnt_zero;
   assign ultimo  = amostra && (cnt_contagem == CW'(1));

   always_comb begin
      estado_d     = estado_q;
      modo_d       = MODO_MANTEM;
      valores_d    = valores_q;
      bit_saida_d  = bit_saida_q;
      bit_valido_d = 1'b0;
      ocupado_d    = ocupado_q;
      uns_d        = uns_q;
      cnt_carga    = 1'b0;
      cnt_en       = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (in_valid && in_ready_q) begin
               valores_d = in_dado;
               ocupado_d = 1'b1;
               uns_d     = '0;
               estado_d  = CARGA;
               modo_d    = MODO_CARGA;
            end
         end
         CARGA: begin
            cnt_carga = 1'b1;
            estado_d  = DESLOCA;
            modo_d    = pausa ? MODO_MANTEM : MODO_DESLOCA;
         end
         DESLOCA: begin
            modo_d = pausa ? MODO_MANTEM : MODO_DESLOCA;
            if (amostra) begin
               bit_saida_d  = serial_q;
               bit_valido_d = 1'b1;
               uns_d        = uns_q + CW'(serial_q);
               cnt_en       = 1'b1;
               if (ultimo) begin
                  estado_d = FIM;
                  modo_d   = MODO_MANTEM;
               end
            end
         end
         FIM: begin
            ocupado_d = 1'b0;
            estado_d  = OCIOSO;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q     <= OCIOSO;
         modo_q       <= MODO_MANTEM;
         valores_q    <= '0;
         in_ready_q   <= 1'b0;
         bit_saida_q  <= 1'b0;
         bit_valido_q <= 1'b0;
         done_q       <= 1'b0;
         ocupado_q    <= 1'b0;
         uns_q        <= '0;
      end else begin
         estado_q     <= estado_d;
         modo_q       <= modo_d;
         valores_q    <= valores_d;
         in_ready_q   <= (estado_d == OCIOSO);
         bit_saida_q  <= bit_saida_d;
         bit_valido_q <= bit_valido_d;
         done_q       <= (estado_q == FIM);
         ocupado_q    <= ocupado_d;
         uns_q        <= uns_d;
      end
   end

   assign ch1                 = modo_q[1];
   assign ch0                 = modo_q[0];
   assign in_ready            = in_ready_q;
   assign valores_registrador = valores_q;
   assign bit_saida           = bit_saida_q;
   assign bit_valido          = bit_valido_q;
   assign done                = done_q;
   assign ocupado             = ocupado_q;
   assign contagem_uns        = uns_q;

endmodule

// File: tb/tb_controle_registrador_deslocamento.sv
// Bench for the shift-chain controller with a behavioural 8-stage chain attached.
module tb_controle_registrador_deslocamento;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_dado;
   logic       pausa;
   logic       serial_q;
   logic       ch1, ch0;
   logic [7:0] valores_registrador;
   logic       bit_saida, bit_valido, done, ocupado;
   logic [3:0] contagem_uns;

   int erros  = 0;
   int checks = 0;

   logic       exp_bits[$];
   logic [3:0] exp_cont[$];
   logic [7:0] cadeia;

   typedef struct {
      logic [7:0] w;
      int         p_apos;
      int         p_len;
      int         exp_ciclos;
      int         exp_uns;
   } vetor_t;

   vetor_t tab[4];

   always #5 clk = ~clk;

   controle_registrador_deslocamento #(.WIDTH(8), .CW(4)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_dado             (in_dado),
      .pausa               (pausa),
      .serial_q            (serial_q),
      .ch1                 (ch1),
      .ch0                 (ch0),
      .valores_registrador (valores_registrador),
      .bit_saida           (bit_saida),
      .bit_valido          (bit_valido),
      .done                (done),
      .ocupado             (ocupado),
      .contagem_uns        (contagem_uns)
   );

   // Chain model: 00 load, 01 shift toward stage 0, otherwise hold.
   always_ff @(posedge clk) begin
      case ({ch1, ch0})
         2'b00:   cadeia <= valores_registrador;
         2'b01:   cadeia <= {1'b0, cadeia[7:1]};
         default: cadeia <= cadeia;
      endcase
   end
   assign serial_q = cadeia[0];

   task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         erros++;
         $display("FAIL %s: got=%0h expected=%0h", nome, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bit_valido === 1'b1) begin
         if (exp_bits.size() == 0) chk("bit_inesperado", 1, 0);
         else chk("bit_saida", bit_saida, exp_bits.pop_front());
      end
      if (done === 1'b1) begin
         if (exp_cont.size() == 0) chk("done_inesperado", 1, 0);
         else chk("contagem_uns", contagem_uns, exp_cont.pop_front());
      end
   end

   task automatic chk_reset(input string nome);
      chk({nome, "_modo"}, {ch1, ch0}, 2'b11);
      chk({nome, "_in_ready"}, in_ready, 0);
      chk({nome, "_valores"}, valores_registrador, 0);
      chk({nome, "_bit_saida"}, bit_saida, 0);
      chk({nome, "_bit_valido"}, bit_valido, 0);
      chk({nome, "_done"}, done, 0);
      chk({nome, "_ocupado"}, ocupado, 0);
      chk({nome, "_uns"}, contagem_uns, 0);
   endtask

   // Called just after a negedge. Returns at the negedge where done is seen,
   // or right after an asynchronous reset when abortar > 0.
   task automatic enviar(input logic [7:0] w, input int p_apos, input int p_len,
                         input int exp_uns, input int abortar, input bit manter,
                         input logic [7:0] prox, output int ciclos, output int espera);
      int  n00, n01, n11, nval, ult, pcount, k;
      bit  ocup_ok, rdy_ok, pausado, viu_done;
      n00 = 0; n01 = 0; n11 = 0; nval = 0; ult = 0; pcount = 0;
      ocup_ok = 1; rdy_ok = 1; pausado = 0; viu_done = 0;
      ciclos = 0; espera = 0;
      for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
      if (abortar == 0) exp_cont.push_back(4'(exp_uns));
      in_valid = 1'b1;
      in_dado  = w;
      while (in_ready !== 1'b1 && espera < 50) begin
         @(negedge clk);
         espera++;
      end
      if (in_ready !== 1'b1) begin
         chk("timeout_aceite", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      if (manter) in_dado = prox;
      else in_valid = 1'b0;
      for (k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            viu_done = 1;
            break;
         end
         case ({ch1, ch0})
            2'b00:   n00++;
            2'b01:   n01++;
            2'b11:   n11++;
            default: chk("modo_realimenta", {ch1, ch0}, 2'b11);
         endcase
         if (bit_valido === 1'b1) begin
            nval++;
            ult = k;
         end
         if (ocupado !== 1'b1) ocup_ok = 0;
         if (in_ready !== 1'b0) rdy_ok = 0;
         if (abortar > 0 && nval == abortar) begin
            #2 rst_n = 1'b0;
            #1 chk_reset("reset_meio");
            exp_bits.delete();
            ciclos = k;
            return;
         end
         if (pcount > 0) begin
            pcount--;
            if (pcount == 0) pausa = 1'b0;
         end else if (p_len > 0 && !pausado && nval == p_apos) begin
            pausa   = 1'b1;
            pcount  = p_len;
            pausado = 1;
         end
      end
      if (!viu_done) chk("timeout_done", 0, 1);
      ciclos = k;
      chk("ciclos_modo_carga", n00, 1);
      chk("ciclos_modo_desloca", n01, 8);
      chk("ciclos_modo_mantem", n11, 1 + p_len);
      chk("num_bit_valido", nval, 8);
      chk("done_apos_ultimo_bit", ult, ciclos - 1);
      chk("ocupado_durante", ocup_ok, 1);
      chk("in_ready_baixo_durante", rdy_ok, 1);
      chk("ocupado_no_done", ocupado, 0);
      chk("in_ready_no_done", in_ready, 1);
   endtask

   initial begin
      int ciclos, espera;
      tab[0] = '{w: 8'hA5, p_apos: 0, p_len: 0, exp_ciclos: 11, exp_uns: 4};
      tab[1] = '{w: 8'hA5, p_apos: 2, p_len: 3, exp_ciclos: 14, exp_uns: 4};
      tab[2] = '{w: 8'h80, p_apos: 0, p_len: 0, exp_ciclos: 11, exp_uns: 1};
      tab[3] = '{w: 8'h3C, p_apos: 0, p_len: 0, exp_ciclos: 11, exp_uns: 4};

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_dado  = 8'h00;
      pausa    = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst_n = 1'b1;
      #1 chk("in_ready_antes_borda", in_ready, 0);
      @(negedge clk);
      chk("in_ready_apos_reset", in_ready, 1);
      chk("modo_ocioso", {ch1, ch0}, 2'b11);
      chk("ocupado_ocioso", ocupado, 0);
      chk("bit_valido_ocioso", bit_valido, 0);

      for (int i = 0; i < 4; i++) begin
         enviar(tab[i].w, tab[i].p_apos, tab[i].p_len, tab[i].exp_uns, 0, 1'b0, 8'h00,
                ciclos, espera);
         chk("latencia_done", ciclos, tab[i].exp_ciclos);
         repeat (2) @(negedge clk);
      end

      // Back-to-back with in_valid held: second accept right after done.
      enviar(8'hFF, 0, 0, 8, 0, 1'b1, 8'h00, ciclos, espera);
      chk("latencia_ff", ciclos, 11);
      enviar(8'h00, 0, 0, 0, 0, 1'b0, 8'h00, ciclos, espera);
      chk("aceite_apos_done", espera, 0);
      chk("latencia_00", ciclos, 11);
      repeat (2) @(negedge clk);

      // Reset mid-word, then a fresh word must serialize from bit 0.
      enviar(8'h3C, 0, 0, 0, 4, 1'b0, 8'h00, ciclos, espera);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      enviar(8'h01, 0, 0, 1, 0, 1'b0, 8'h00, ciclos, espera);
      chk("latencia_01", ciclos, 11);
      repeat (3) @(negedge clk);

      chk("fila_bits_vazia", exp_bits.size(), 0);
      chk("fila_cont_vazia", exp_cont.size(), 0);
      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
